flash_adc_sampler: RTL and testbench
====================================

// Module: flash_adc_sampler
// PURPOSE
//   Downstream consumer of the 3-bit flash-ADC encoder (code + millivolt value).
//   Samples the encoder at a fixed rate through a 2-flop synchroniser and rejects glitches.
//   Averages 2**AVG_LOG2 samples into one result with valid/ready to the display stage.
//   Tracks running min/max millivolts and flags results lost to backpressure.
// PARAMETERS
//   CLK_HZ     100_000_000  system clock frequency
//   SAMPLE_HZ  1_000        sample tick rate; DIV = CLK_HZ/SAMPLE_HZ, must be >= 4
//   AVG_LOG2   4            log2 of samples per result (1..8)
//   MV_W       16           millivolt bus width
// PORTS
//   clk           in   1         system clock, all logic on rising edge
//   rst_n         in   1         asynchronous active-low reset
//   enable        in   1         1 = run sampling/averaging
//   code_in       in   3         encoder code, asynchronous to clk
//   mv_in         in   MV_W      encoder millivolt value, asynchronous to clk
//   clear_minmax  in   1         1-cycle pulse: reset min/max trackers
//   out_ready     in   1         downstream accepts result
//   out_valid     out  1         result registers hold an unconsumed result
//   avg_code      out  3         floor(sum codes / 2**AVG_LOG2)
//   avg_mv        out  MV_W      floor(sum mv / 2**AVG_LOG2)
//   min_mv        out  MV_W      smallest accepted sample since reset/clear
//   max_mv        out  MV_W      largest accepted sample since reset/clear
//   overrun       out  1         sticky: a result was overwritten while unconsumed
// BEHAVIOUR
//   Reset: out_valid=0, avg_code=0, avg_mv=0, min_mv='1, max_mv=0, overrun=0.
//   Reset also clears the tick counter, accumulators and sample count, and puts the FSM in IDLE.
//   Synchroniser: {code_in,mv_in} go through 2 flops every clk. Sample = sync stage-2 value.
//   Glitch reject: a tick's sample is accepted only if stage-2 equals the previous stage-2 value.
//   A rejected tick is skipped; it does not advance the sample count.
//   Tick: counter runs 0..DIV-1 while enable=1; tick at DIV-1, then wraps to 0.
//   The counter is held at 0 while enable=0.
//   FSM IDLE: enable=0. On enable=1, go to ACCUM with acc=0 and cnt=0.
//   FSM ACCUM, accepted tick: acc_mv+=sample_mv (width MV_W+AVG_LOG2), acc_code+=code
//   (width 3+AVG_LOG2), cnt++.
//   If the tick makes cnt reach 2**AVG_LOG2, then on that same edge:
//     - load avg_* = acc >> AVG_LOG2, including that sample;
//     - set out_valid=1;
//     - clear acc and cnt, stay in ACCUM.
//   Latency: out_valid rises on the clk edge of the final accepted tick.
//   Handshake: a transfer happens on an edge with out_valid&&out_ready.
//     - out_valid falls on that edge unless a new result loads on the same edge; then it stays 1.
//     - avg_* are stable while out_valid=1 && !out_ready.
//   Overrun: a new result loading while out_valid=1 && !out_ready overwrites avg_* and sets overrun.
//     overrun clears only on reset or clear_minmax.
//   Min/max: every accepted sample updates min_mv=min(), max_mv=max().
//     clear_minmax alone sets min_mv='1, max_mv=0.
//     clear_minmax together with an accepted sample sets min_mv=max_mv=sample.
//   enable 1->0 mid-block: FSM to IDLE; partial acc/cnt are discarded.
//     The output registers, out_valid and min/max are retained; the handshake still completes.
//   No arithmetic overflow: the accumulator widths are exact for 2**AVG_LOG2 full-scale samples.
// STRUCTURE
//   adc_pkg (shared): MV_W, ADC_CODE_W=3, encoder scale constants (471 mV step, 3300 full scale),
//     typedef enum {IDLE, ACCUM} adc_samp_state_t.
//   Sub-module adc_tick_gen (params CLK_HZ, SAMPLE_HZ; ports clk, rst_n, enable, tick).
//   The synchroniser, glitch filter, FSM, accumulators, min/max and output register stay in this module.
// TESTING (CLK_HZ=1000, SAMPLE_HZ=100 -> DIV=10, AVG_LOG2=2)
//   1 Reset with rst_n low mid-cycle -> all outputs take reset values immediately, no clk needed.
//   2 code=3, mv=1413 held; enable=1; out_ready=1 -> first out_valid at 4th accepted tick (~cycle 40+sync),
//     with avg_code=3, avg_mv=1413, min=max=1413.
//   3 Samples 0,471,942,1884 mV with codes 0,1,2,4 -> avg_mv=824, avg_code=1, min_mv=0, max_mv=1884.
//   4 out_ready=0 across two result blocks -> first result held stable, then overwritten by the second.
//     overrun=1; clear_minmax -> overrun=0.
//   5 mv_in toggles every clk around the tick -> samples rejected, cnt does not advance, no out_valid.
//   6 Drop enable after 2 of 4 samples, re-enable -> the next result uses 4 fresh samples only.
//     The pending result is still delivered on out_ready.

Source files
------------

// File: rtl/flash_adc_sampler_pkg.sv
// Shared definitions for the flash-ADC sampling path: bus widths, encoder
// scale constants and the sampler FSM state type.
package flash_adc_sampler_pkg;

  localparam int unsigned MV_W              = 16;
  localparam int unsigned ADC_CODE_W        = 3;
  localparam int unsigned ADC_STEP_MV       = 471;
  localparam int unsigned ADC_FULL_SCALE_MV = 3300;

  typedef enum logic {
    IDLE,
    ACCUM
  } adc_samp_state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flash_adc_sampler_if.sv
// Encoder-side inputs and display-side result handshake of the sampler.
interface flash_adc_sampler_if
  import flash_adc_sampler_pkg::*;
#(
  parameter int unsigned MV_W = flash_adc_sampler_pkg::MV_W
) ();

  logic                  enable;
  logic [ADC_CODE_W-1:0] code_in;
  logic [MV_W-1:0]       mv_in;
  logic                  clear_minmax;
  logic                  out_ready;
  logic                  out_valid;
  logic [ADC_CODE_W-1:0] avg_code;
  logic [MV_W-1:0]       avg_mv;
  logic [MV_W-1:0]       min_mv;
  logic [MV_W-1:0]       max_mv;
  logic                  overrun;

  // Sampler side.
  modport slave (
    input  enable, code_in, mv_in, clear_minmax, out_ready,
    output out_valid, avg_code, avg_mv, min_mv, max_mv, overrun
  );

  // Controller / consumer side.
  modport master (
    output enable, code_in, mv_in, clear_minmax, out_ready,
    input  out_valid, avg_code, avg_mv, min_mv, max_mv, overrun
  );

endinterface

// File: rtl/flash_adc_sampler_tick_gen.sv
// Sample-rate tick: counts 0..DIV-1 while enabled, ticks on DIV-1.
module adc_tick_gen
  import flash_adc_sampler_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_HZ = 1_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned CW  = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick decode and counter advance; counter parked at 0 while disabled.
  always_comb begin
    tick  = enable && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/flash_adc_sampler.sv
// Samples the flash-ADC encoder through a 2-flop synchroniser, rejects
// samples that changed since the previous clock, averages 2**AVG_LOG2
// accepted samples into a valid/ready result and tracks min/max millivolts.
module flash_adc_sampler
  import flash_adc_sampler_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_HZ = 1_000,
  parameter int unsigned AVG_LOG2  = 4,
  parameter int unsigned MV_W      = flash_adc_sampler_pkg::MV_W
) (
  input  logic                clk,
  input  logic                rst_n,
  flash_adc_sampler_if.slave  bus
);

  localparam int unsigned SW    = ADC_CODE_W + MV_W;
  localparam int unsigned ACC_W = MV_W + AVG_LOG2;
  localparam int unsigned ACC_C = ADC_CODE_W + AVG_LOG2;

  logic [SW-1:0]         sync1_q, sync2_q, prev_q;
  logic                  tick;
  logic                  accept;
  logic [ADC_CODE_W-1:0] sample_code;
  logic [MV_W-1:0]       sample_mv;

  adc_samp_state_t       state_q, state_d;
  logic [ACC_W-1:0]      acc_mv_q, acc_mv_d, acc_mv_sum;
  logic [ACC_C-1:0]      acc_code_q, acc_code_d, acc_code_sum;
  logic [AVG_LOG2-1:0]   cnt_q, cnt_d;
  logic                  load;

  logic                  valid_q, valid_d;
  logic [ADC_CODE_W-1:0] avg_code_q, avg_code_d;
  logic [MV_W-1:0]       avg_mv_q, avg_mv_d;
  logic [MV_W-1:0]       min_q, min_d, max_q, max_d;
  logic                  ovr_q, ovr_d;

  adc_tick_gen #(
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (bus.enable),
    .tick   (tick)
  );

  // Two-flop synchroniser plus one extra stage holding the previous stage-2 value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {bus.code_in, bus.mv_in};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sample_code = sync2_q[SW-1 -: ADC_CODE_W];
  assign sample_mv   = sync2_q[MV_W-1:0];
  assign accept      = tick && (sync2_q == prev_q);

  // FSM next state and accumulators; the final sample of a block is folded
  // into the result through the *_sum terms on the same edge that loads it.
  always_comb begin
    state_d      = state_q;
    acc_mv_d     = acc_mv_q;
    acc_code_d   = acc_code_q;
    cnt_d        = cnt_q;
    load         = 1'b0;
    acc_mv_sum   = acc_mv_q + ACC_W'(sample_mv);
    acc_code_sum = acc_code_q + ACC_C'(sample_code);
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d    = ACCUM;
          acc_mv_d   = '0;
          acc_code_d = '0;
          cnt_d      = '0;
        end
      end
      ACCUM: begin
        if (!bus.enable) begin
          state_d    = IDLE;
          acc_mv_d   = '0;
          acc_code_d = '0;
          cnt_d      = '0;
        end else if (accept) begin
          if (cnt_q == '1) begin
            load       = 1'b1;
            acc_mv_d   = '0;
            acc_code_d = '0;
            cnt_d      = '0;
          end else begin
            acc_mv_d   = acc_mv_sum;
            acc_code_d = acc_code_sum;
            cnt_d      = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // FSM state and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_mv_q   <= '0;
      acc_code_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_mv_q   <= acc_mv_d;
      acc_code_q <= acc_code_d;
      cnt_q      <= cnt_d;
    end
  end

  // Result handshake, overrun flag and min/max trackers. A clear followed by
  // an accepted sample on the same edge leaves min=max=sample.
  always_comb begin
    valid_d    = valid_q;
    avg_code_d = avg_code_q;
    avg_mv_d   = avg_mv_q;
    min_d      = min_q;
    max_d      = max_q;
    ovr_d      = ovr_q;
    if (bus.clear_minmax) begin
      min_d = '1;
      max_d = '0;
      ovr_d = 1'b0;
    end
    if (accept) begin
      if (sample_mv < min_d) min_d = sample_mv;
      if (sample_mv > max_d) max_d = sample_mv;
    end
    if (load) begin
      if (valid_q && !bus.out_ready) ovr_d = 1'b1;
      valid_d    = 1'b1;
      avg_code_d = acc_code_sum[AVG_LOG2 +: ADC_CODE_W];
      avg_mv_d   = acc_mv_sum[AVG_LOG2 +: MV_W];
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      avg_code_q <= '0;
      avg_mv_q   <= '0;
      min_q      <= '1;
      max_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      avg_code_q <= avg_code_d;
      avg_mv_q   <= avg_mv_d;
      min_q      <= min_d;
      max_q      <= max_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.avg_code  = avg_code_q;
  assign bus.avg_mv    = avg_mv_q;
  assign bus.min_mv    = min_q;
  assign bus.max_mv    = max_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_flash_adc_sampler.sv
// Directed and randomized checks of flash_adc_sampler against a
// sample-queue reference model.
module tb_flash_adc_sampler;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned SAMPLE_HZ = 100;
  localparam int unsigned DIV       = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned AVG_LOG2  = 2;
  localparam int unsigned NSAMP     = 1 << AVG_LOG2;

  logic clk;
  logic rst_n;

  flash_adc_sampler_if #(.MV_W(16)) bus ();

  flash_adc_sampler #(
    .CLK_HZ    (CLK_HZ),
    .SAMPLE_HZ (SAMPLE_HZ),
    .AVG_LOG2  (AVG_LOG2),
    .MV_W      (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int unsigned m_div;
  logic [18:0] hist [3];
  int unsigned q_mv[$];
  int unsigned q_code[$];
  logic        m_valid;
  logic [2:0]  m_avg_code;
  logic [15:0] m_avg_mv, m_min, m_max;
  logic        m_ovr;
  int unsigned m_accepts = 0;
  bit          m_tick, m_acc, m_load;
  int unsigned s_mv, s_code, sum_mv, sum_code;

  // Reference: a tick every DIV enabled cycles; a tick's sample is the input
  // seen two clocks earlier, kept only if it equals the one three clocks earlier.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div = 0;
      for (int i = 0; i < 3; i++) hist[i] = '0;
      q_mv.delete();
      q_code.delete();
      m_valid = 0; m_avg_code = 0; m_avg_mv = 0;
      m_min = 16'hFFFF; m_max = 0; m_ovr = 0;
    end else begin
      m_tick = bus.enable && (m_div == DIV - 1);
      m_div  = (!bus.enable || m_tick) ? 0 : m_div + 1;
      m_acc  = m_tick && (hist[1] == hist[2]);
      m_load = 0;
      if (!bus.enable) begin
        q_mv.delete();
        q_code.delete();
      end
      if (bus.clear_minmax) begin
        m_min = 16'hFFFF; m_max = 0; m_ovr = 0;
      end
      if (m_acc) begin
        s_mv   = hist[1][15:0];
        s_code = hist[1][18:16];
        m_accepts++;
        if (s_mv < m_min) m_min = s_mv[15:0];
        if (s_mv > m_max) m_max = s_mv[15:0];
        q_mv.push_back(s_mv);
        q_code.push_back(s_code);
        if (q_mv.size() == NSAMP) begin
          sum_mv = 0; sum_code = 0;
          foreach (q_mv[i]) begin
            sum_mv   += q_mv[i];
            sum_code += q_code[i];
          end
          m_load = 1;
          q_mv.delete();
          q_code.delete();
        end
      end
      if (m_load) begin
        if (m_valid && !bus.out_ready) m_ovr = 1;
        m_valid    = 1;
        m_avg_mv   = 16'(sum_mv / NSAMP);
        m_avg_code = 3'(sum_code / NSAMP);
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {bus.code_in, bus.mv_in};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".avg_code"},  32'(bus.avg_code),  32'(m_avg_code));
    chk({tag, ".avg_mv"},    32'(bus.avg_mv),    32'(m_avg_mv));
    chk({tag, ".min_mv"},    32'(bus.min_mv),    32'(m_min));
    chk({tag, ".max_mv"},    32'(bus.max_mv),    32'(m_max));
    chk({tag, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_all("cyc");
  endtask

  // Run until n more samples are accepted, within a cycle budget.
  task automatic wait_accepts(input int unsigned n, input bit rnd_ready);
    int unsigned target;
    int unsigned budget;
    target = m_accepts + n;
    budget = n * DIV + 30;
    while (m_accepts < target && budget > 0) begin
      if (rnd_ready) bus.out_ready = 1'($urandom % 2);
      cyc();
      budget--;
    end
    checks++;
    assert (m_accepts >= target) else begin
      errors++;
      $error("FAIL accept_timeout observed=%0d expected=%0d", m_accepts, target);
    end
  endtask

  task automatic set_in(input int unsigned code, input int unsigned mv);
    bus.code_in = 3'(code);
    bus.mv_in   = 16'(mv);
  endtask

  int unsigned va, vb, vc, vd, ve, ce;
  logic [15:0] toggled;

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.clear_minmax = 1'b0; bus.out_ready = 1'b0;
    set_in(0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");
    chk("reset.min_const", 32'(bus.min_mv), 32'hFFFF);

    // Constant input, first result after four accepted ticks.
    set_in(3, 1413);
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    bus.enable = 1'b1;
    wait_accepts(NSAMP, 0);
    chk("t2.valid", 32'(bus.out_valid), 1);
    chk("t2.code",  32'(bus.avg_code), 3);
    chk("t2.mv",    32'(bus.avg_mv), 1413);
    chk("t2.min",   32'(bus.min_mv), 1413);
    chk("t2.max",   32'(bus.max_mv), 1413);

    // Ramp of encoder levels.
    bus.enable = 1'b0;
    bus.clear_minmax = 1'b1;
    set_in(0, 0);
    cyc();
    bus.clear_minmax = 1'b0;
    cyc();
    bus.enable = 1'b1;
    wait_accepts(1, 0);
    set_in(1, 471);  wait_accepts(1, 0);
    set_in(2, 942);  wait_accepts(1, 0);
    set_in(4, 1884); wait_accepts(1, 0);
    chk("t3.mv",   32'(bus.avg_mv), 824);
    chk("t3.code", 32'(bus.avg_code), 1);
    chk("t3.min",  32'(bus.min_mv), 0);
    chk("t3.max",  32'(bus.max_mv), 1884);

    // Backpressure across two blocks.
    cyc();
    bus.out_ready = 1'b0;
    va = $urandom_range(0, 3300);
    vb = (va + 1000) % 3301;
    set_in(5, va);
    wait_accepts(NSAMP, 0);
    chk("t4.first", 32'(bus.avg_mv), va);
    set_in(6, vb);
    wait_accepts(NSAMP - 1, 0);
    chk("t4.held_mv",    32'(bus.avg_mv), va);
    chk("t4.held_valid", 32'(bus.out_valid), 1);
    chk("t4.no_ovr",     32'(bus.overrun), 0);
    wait_accepts(1, 0);
    chk("t4.second", 32'(bus.avg_mv), vb);
    chk("t4.ovr",    32'(bus.overrun), 1);
    bus.clear_minmax = 1'b1;
    cyc();
    bus.clear_minmax = 1'b0;
    chk("t4.ovr_clr", 32'(bus.overrun), 0);
    chk("t4.min_clr", 32'(bus.min_mv), 32'hFFFF);
    bus.out_ready = 1'b1;
    cyc();
    chk("t4.drained", 32'(bus.out_valid), 0);

    // Input changing every clock: every tick rejected.
    toggled = 16'd1000;
    for (int i = 0; i < 6 * DIV; i++) begin
      toggled = toggled ^ 16'd1;
      set_in(2, toggled);
      cyc();
    end
    chk("t5.valid", 32'(bus.out_valid), 0);
    chk("t5.min",   32'(bus.min_mv), 32'hFFFF);
    chk("t5.max",   32'(bus.max_mv), 0);

    // Enable dropped mid-block; pending result survives.
    bus.out_ready = 1'b0;
    vc = $urandom_range(0, 3300);
    vd = 3300;
    ve = $urandom_range(0, 1000);
    ce = $urandom_range(0, 3);
    set_in(1, vc);
    wait_accepts(NSAMP, 0);
    set_in(7, vd);
    wait_accepts(2, 0);
    bus.enable = 1'b0;
    cyc();
    chk("t6.pending_valid", 32'(bus.out_valid), 1);
    chk("t6.pending_mv",    32'(bus.avg_mv), vc);
    bus.out_ready = 1'b1;
    cyc();
    chk("t6.delivered", 32'(bus.out_valid), 0);
    set_in(ce, ve);
    cyc();
    bus.enable = 1'b1;
    wait_accepts(NSAMP, 0);
    chk("t6.fresh_mv",   32'(bus.avg_mv), ve);
    chk("t6.fresh_code", 32'(bus.avg_code), ce);

    // Random samples, random backpressure, occasional tracker clears.
    for (int i = 0; i < 40; i++) begin
      set_in($urandom_range(0, 7), $urandom_range(0, 3300));
      if ($urandom % 8 == 0) begin
        bus.clear_minmax = 1'b1;
        cyc();
        bus.clear_minmax = 1'b0;
      end
      wait_accepts(1, 1);
    end

    // Asynchronous reset asserted between clock edges.
    bus.out_ready = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(bus.out_valid), 0);
    chk("arst.code",  32'(bus.avg_code), 0);
    chk("arst.mv",    32'(bus.avg_mv), 0);
    chk("arst.min",   32'(bus.min_mv), 32'hFFFF);
    chk("arst.max",   32'(bus.max_mv), 0);
    chk("arst.ovr",   32'(bus.overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
